// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared sizes and port FSM state encoding for line_memory
package mem_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int FETCH_SIZE = 64;
    localparam int LINE_WORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RDATA = 2'd2,
        ST_WDONE = 2'd3
    } port_state_e;

endpackage

// File: rtl/mem_port_fsm.sv
// rtl/mem_port_fsm.sv - per-port request FSM producing write-commit and bus-drive enables
module mem_port_fsm
    import mem_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_read,
    input  logic i_write,
    output logic o_commit,
    output logic o_drive,
    output logic o_read_done
);

    localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

    port_state_e r_state;
    port_state_e w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        w_req;
    logic        w_last;

    assign w_req  = i_read | i_write;
    // The counter holds completed request cycles, so the final request cycle sees LATENCY-1.
    assign w_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_next = ST_WAIT;
                    w_cnt_next   = 4'd1;
                end
            end
            ST_WAIT: begin
                if (!w_req) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (w_last) begin
                    w_state_next = i_write ? ST_WDONE : ST_RDATA;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            ST_RDATA: begin
                if (!i_read) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WDONE: begin
                if (!i_write) begin
                    if (i_read) begin
                        w_state_next = ST_WAIT;
                        w_cnt_next   = 4'd1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        o_commit    = 1'b0;
        o_drive     = 1'b0;
        o_read_done = 1'b0;
        case (r_state)
            ST_WAIT: begin
                o_commit = w_last & i_write;
                o_drive  = w_last & i_read & ~i_write;
            end
            ST_RDATA: begin
                o_drive     = i_read;
                o_read_done = ~i_read;
            end
            default: begin
                o_commit = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/line_memory.sv
// rtl/line_memory.sv - dual-port 64-bit line store with per-port latency FSMs
// Optional request statistics outputs are built when LINE_MEMORY_STATS_EN is defined.
module line_memory
    import mem_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int MEM_LINES = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_readM,
    input  logic                  i_writeM,
    input  logic [WORD_SIZE-1:0]  i_addressM,
    inout  wire  [FETCH_SIZE-1:0] i_dataM,
    input  logic                  d_readM,
    input  logic                  d_writeM,
    input  logic [WORD_SIZE-1:0]  d_addressM,
    inout  wire  [FETCH_SIZE-1:0] d_dataM
`ifdef LINE_MEMORY_STATS_EN
    ,
    output logic [15:0]           i_read_cnt,
    output logic [15:0]           d_read_cnt,
    output logic [15:0]           d_write_cnt
`endif
);

    localparam int OFS_BITS  = $clog2(LINE_WORDS);
    localparam int LINE_BITS = $clog2(MEM_LINES);

    logic [FETCH_SIZE-1:0] r_mem [MEM_LINES];

    logic [LINE_BITS-1:0] w_i_line;
    logic [LINE_BITS-1:0] w_d_line;
    logic w_i_commit, w_i_drive, w_i_read_done;
    logic w_d_commit, w_d_drive, w_d_read_done;
    logic w_unused_addr;

    // Upper address bits are dropped so accesses wrap onto the storage depth.
    assign w_i_line = i_addressM[LINE_BITS+OFS_BITS-1:OFS_BITS];
    assign w_d_line = d_addressM[LINE_BITS+OFS_BITS-1:OFS_BITS];
    assign w_unused_addr = ^{i_addressM[OFS_BITS-1:0], i_addressM[WORD_SIZE-1:LINE_BITS+OFS_BITS],
                             d_addressM[OFS_BITS-1:0], d_addressM[WORD_SIZE-1:LINE_BITS+OFS_BITS]};

    mem_port_fsm #(.LATENCY(LATENCY)) u_i_fsm (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_read      (i_readM),
        .i_write     (i_writeM),
        .o_commit    (w_i_commit),
        .o_drive     (w_i_drive),
        .o_read_done (w_i_read_done)
    );

    mem_port_fsm #(.LATENCY(LATENCY)) u_d_fsm (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_read      (d_readM),
        .i_write     (d_writeM),
        .o_commit    (w_d_commit),
        .o_drive     (w_d_drive),
        .o_read_done (w_d_read_done)
    );

    // The d-port write is issued last so it wins a same-line collision.
    always_ff @(posedge clk) begin
        if (w_i_commit) begin
            r_mem[w_i_line] <= i_dataM;
        end
        if (w_d_commit) begin
            r_mem[w_d_line] <= d_dataM;
        end
    end

    assign i_dataM = w_i_drive ? r_mem[w_i_line] : {FETCH_SIZE{1'bz}};
    assign d_dataM = w_d_drive ? r_mem[w_d_line] : {FETCH_SIZE{1'bz}};

`ifdef LINE_MEMORY_STATS_EN
    logic [15:0] r_i_read_cnt;
    logic [15:0] r_d_read_cnt;
    logic [15:0] r_d_write_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i_read_cnt  <= '0;
            r_d_read_cnt  <= '0;
            r_d_write_cnt <= '0;
        end else begin
            if (w_i_read_done && (r_i_read_cnt != 16'hFFFF)) begin
                r_i_read_cnt <= r_i_read_cnt + 16'd1;
            end
            if (w_d_read_done && (r_d_read_cnt != 16'hFFFF)) begin
                r_d_read_cnt <= r_d_read_cnt + 16'd1;
            end
            if (w_d_commit && (r_d_write_cnt != 16'hFFFF)) begin
                r_d_write_cnt <= r_d_write_cnt + 16'd1;
            end
        end
    end

    assign i_read_cnt  = r_i_read_cnt;
    assign d_read_cnt  = r_d_read_cnt;
    assign d_write_cnt = r_d_write_cnt;
`else
    logic w_unused_done;
    assign w_unused_done = w_i_read_done ^ w_d_read_done;
`endif

endmodule

// File: tb/tb_line_memory.sv
// tb/tb_line_memory.sv - scoreboard bench for line_memory (stats checks when LINE_MEMORY_STATS_EN is defined)
module tb_line_memory;

    localparam int          LAT = 4;
    localparam logic [63:0] HIZ = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_readM, i_writeM, d_readM, d_writeM;
    logic [15:0] i_addressM, d_addressM;
    wire  [63:0] i_dataM, d_dataM;
    logic        i_drv_en, d_drv_en;
    logic [63:0] i_drv, d_drv;

`ifdef LINE_MEMORY_STATS_EN
    logic [15:0] i_read_cnt, d_read_cnt, d_write_cnt;
`endif

    always #5 clk = ~clk;

    // An undriven bus floats to all ones through the pullups.
    assign i_dataM = i_drv_en ? i_drv : 64'bz;
    assign d_dataM = d_drv_en ? d_drv : 64'bz;
    pullup (i_dataM);
    pullup (d_dataM);

    line_memory #(.LATENCY(LAT), .MEM_LINES(256)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_readM    (i_readM),
        .i_writeM   (i_writeM),
        .i_addressM (i_addressM),
        .i_dataM    (i_dataM),
        .d_readM    (d_readM),
        .d_writeM   (d_writeM),
        .d_addressM (d_addressM),
        .d_dataM    (d_dataM)
`ifdef LINE_MEMORY_STATS_EN
        ,
        .i_read_cnt (i_read_cnt),
        .d_read_cnt (d_read_cnt),
        .d_write_cnt(d_write_cnt)
`endif
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] model [256];
    logic [63:0] i_q[$];
    logic [63:0] d_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] line_of(input logic [15:0] a);
        return a[9:2];
    endfunction

    function automatic logic [63:0] bus(input bit dp);
        return dp ? d_dataM : i_dataM;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_port(input bit dp, input logic rd, input logic wr, input logic [15:0] a);
        if (dp) begin
            d_readM = rd; d_writeM = wr; d_addressM = a;
        end else begin
            i_readM = rd; i_writeM = wr; i_addressM = a;
        end
    endtask

    task automatic drive(input bit dp, input logic en, input logic [63:0] v);
        if (dp) begin
            d_drv_en = en; d_drv = v;
        end else begin
            i_drv_en = en; i_drv = v;
        end
    endtask

    task automatic push_exp(input bit dp, input logic [63:0] v);
        if (dp) d_q.push_back(v);
        else    i_q.push_back(v);
    endtask

    task automatic pop_check(input bit dp, input string tag);
        logic [63:0] exp;
        if ((dp && d_q.size() == 0) || (!dp && i_q.size() == 0)) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %h", tag, bus(dp));
        end else begin
            exp = dp ? d_q.pop_front() : i_q.pop_front();
            check(tag, bus(dp), exp);
        end
    endtask

    task automatic run_write(input bit en_i, input bit en_d, input logic [15:0] ai, input logic [15:0] ad,
                             input logic [63:0] vi, input logic [63:0] vd, input int hold, input bit with_read);
        for (int c = 1; c <= hold; c++) begin
            if (en_i) begin
                set_port(0, with_read, 1'b1, ai);
                drive(0, 1'b1, (c <= LAT) ? vi : ~vi);
            end
            if (en_d) begin
                set_port(1, with_read, 1'b1, ad);
                drive(1, 1'b1, (c <= LAT) ? vd : ~vd);
            end
            tick();
        end
        set_port(0, 1'b0, 1'b0, ai); drive(0, 1'b0, '0);
        set_port(1, 1'b0, 1'b0, ad); drive(1, 1'b0, '0);
        tick();
        if (hold >= LAT) begin
            if (en_i) model[line_of(ai)] = vi;
            if (en_d) model[line_of(ad)] = vd;
        end
    endtask

    task automatic run_read(input bit en_i, input bit en_d, input logic [15:0] ai, input logic [15:0] ad,
                            input bit reread, input logic [15:0] ad2, input string tag);
        if (en_i) begin push_exp(0, model[line_of(ai)]); set_port(0, 1'b1, 1'b0, ai); end
        if (en_d) begin push_exp(1, model[line_of(ad)]); set_port(1, 1'b1, 1'b0, ad); end
        for (int c = 1; c < LAT; c++) begin
            sample();
            if (en_i) check({tag, "_i_hiz"}, bus(0), HIZ);
            if (en_d) check({tag, "_d_hiz"}, bus(1), HIZ);
            tick();
        end
        sample();
        if (en_i) pop_check(0, {tag, "_i_data"});
        if (en_d) pop_check(1, {tag, "_d_data"});
        tick();
        if (reread && en_d) begin
            d_addressM = ad2;
            push_exp(1, model[line_of(ad2)]);
            sample();
            pop_check(1, {tag, "_d_reread"});
            tick();
        end
        if (en_i) set_port(0, 1'b0, 1'b0, ai);
        if (en_d) set_port(1, 1'b0, 1'b0, ad);
        sample();
        if (en_i) check({tag, "_i_release"}, bus(0), HIZ);
        if (en_d) check({tag, "_d_release"}, bus(1), HIZ);
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        set_port(0, 1'b0, 1'b0, '0); drive(0, 1'b0, '0);
        set_port(1, 1'b0, 1'b0, '0); drive(1, 1'b0, '0);
        tick(); tick();
        sample();
        check("reset_i_hiz", bus(0), HIZ);
        check("reset_d_hiz", bus(1), HIZ);
`ifdef LINE_MEMORY_STATS_EN
        check("reset_d_read_cnt", 64'(d_read_cnt), 64'd0);
`endif
        tick();
        reset_n = 1'b1;
        tick();

        // Preload line 0x012, then read it back through the d-port.
        run_write(1, 0, 16'h0048, 16'h0000, 64'h4444_3333_2222_1111, 64'h0, LAT, 0);
        run_read(0, 1, 16'h0000, 16'h0048, 0, 16'h0, "preload");

        // Write held for LATENCY cycles, then a read raised as the write drops.
        set_port(1, 1'b0, 1'b1, 16'h0010);
        drive(1, 1'b1, 64'hDEAD_BEEF_0000_0001);
        repeat (LAT) tick();
        model[line_of(16'h0010)] = 64'hDEAD_BEEF_0000_0001;
        set_port(1, 1'b1, 1'b0, 16'h0010);
        drive(1, 1'b0, '0);
        push_exp(1, model[line_of(16'h0010)]);
        for (int c = 1; c < LAT; c++) begin
            sample(); check("wr_then_rd_hiz", bus(1), HIZ); tick();
        end
        sample(); pop_check(1, "wr_then_rd_data"); tick();
        set_port(1, 1'b0, 1'b0, 16'h0010);
        tick();

        // Concurrent traffic on distinct lines.
        run_write(1, 1, 16'h000C, 16'h001C, 64'hA3A3_0000_0000_0003, 64'hB7B7_0000_0000_0007, LAT, 0);
        run_read(1, 1, 16'h000C, 16'h001C, 0, 16'h0, "concurrent");

        // Same-line collision: d-port must win.
        run_write(1, 1, 16'h0080, 16'h0080, 64'h1111_0000_0000_00AA, 64'h2222_0000_0000_00BB, LAT, 0);
        run_read(1, 0, 16'h0080, 16'h0000, 0, 16'h0, "collision");

        // Long-held write must commit once; later bus values are ignored.
        run_write(1, 0, 16'h0100, 16'h0000, 64'h5555_6666_7777_8888, 64'h0, LAT + 2, 0);
        run_read(1, 0, 16'h0100, 16'h0000, 0, 16'h0, "wdone_hold");

        // Aborted write leaves the line untouched.
        run_write(0, 1, 16'h0000, 16'h0100, 64'h0, 64'h9999_9999_9999_9999, 2, 0);
        run_read(0, 1, 16'h0000, 16'h0100, 0, 16'h0, "wr_abort");

        // Write wins over a simultaneous read request.
        run_write(1, 0, 16'h0140, 16'h0000, 64'hC0DE_C0DE_0000_0050, 64'h0, LAT, 1);
        run_read(0, 1, 16'h0000, 16'h0140, 0, 16'h0, "wr_priority");

        // RDATA follows address changes.
        run_read(0, 1, 16'h0000, 16'h0048, 1, 16'h001C, "reread");

        // Read dropped in cycle 2, re-raised in cycle 3: restarts from scratch.
        set_port(1, 1'b1, 1'b0, 16'h0048);
        sample(); check("rd_abort_c1", bus(1), HIZ); tick();
        set_port(1, 1'b0, 1'b0, 16'h0048);
        sample(); check("rd_abort_c2", bus(1), HIZ); tick();
        set_port(1, 1'b1, 1'b0, 16'h0048);
        push_exp(1, model[line_of(16'h0048)]);
        for (int c = 1; c < LAT; c++) begin
            sample(); check("rd_abort_restart_hiz", bus(1), HIZ); tick();
        end
        sample(); pop_check(1, "rd_abort_restart_data"); tick();
        set_port(1, 1'b0, 1'b0, 16'h0048);
        tick();

        // Address wrap onto 256 lines.
        run_write(0, 1, 16'h0000, 16'hFFF0, 64'h0, 64'h0F0F_F0F0_1234_5678, LAT, 0);
        run_read(0, 1, 16'h0000, 16'h03F0, 0, 16'h0, "wrap");

        // Reset while the bus is driven, then a held request restarts after release.
        set_port(1, 1'b1, 1'b0, 16'h0048);
        push_exp(1, model[line_of(16'h0048)]);
        for (int c = 1; c < LAT; c++) begin
            sample(); check("pre_rst_hiz", bus(1), HIZ); tick();
        end
        sample(); pop_check(1, "pre_rst_data"); tick();
        sample();
        #2 reset_n = 1'b0;
        #1 check("rst_immediate_hiz", bus(1), HIZ);
        tick(); tick();
        reset_n = 1'b1;
        push_exp(1, model[line_of(16'h0048)]);
        for (int c = 1; c < LAT; c++) begin
            sample(); check("post_rst_hiz", bus(1), HIZ); tick();
        end
        sample(); pop_check(1, "post_rst_data"); tick();
        set_port(1, 1'b0, 1'b0, 16'h0048);
        tick();

`ifdef LINE_MEMORY_STATS_EN
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            run_read(0, 1, 16'h0000, 16'h001C, 0, 16'h0, "stats_rd");
        end
        run_write(0, 1, 16'h0000, 16'h0200, 64'h0, 64'h0000_0000_0000_0200, LAT, 0);
        run_write(0, 1, 16'h0000, 16'h0204, 64'h0, 64'h0000_0000_0000_0204, LAT, 0);
        sample();
        check("stats_d_read_cnt", 64'(d_read_cnt), 64'd3);
        check("stats_d_write_cnt", 64'(d_write_cnt), 64'd2);
        check("stats_i_read_cnt", 64'(i_read_cnt), 64'd0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/line_memory.md
LINE_MEMORY -- requirements
Module: line_memory

Interface
REQ-001 Parameter LATENCY, default 4, SHALL set the number of request cycles before read data is valid or a write commits; legal range 2..15.
REQ-002 Parameter MEM_LINES, default 256, SHALL set the storage depth in 64-bit lines; must be a power of two.
REQ-003 clk  input  1  the block's single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_readM  input  1  instruction-port line read request, level-held by the requester.
REQ-006 i_writeM  input  1  instruction-port line write request, level-held.
REQ-007 i_addressM  input  16  instruction-port word address; bits [15:2] select the line.
REQ-008 i_dataM  inout  64  instruction-port line data; driven by this block only during read data phase, high-Z otherwise.
REQ-009 d_readM, d_writeM, d_addressM, d_dataM SHALL mirror REQ-005..REQ-008 for the data port.

Function
REQ-010 Each port SHALL have an independent FSM with states IDLE, WAIT, RDATA, WDONE.
REQ-011 IDLE->WAIT when writeM or readM is sampled high; the cycle counter loads 1.
REQ-012 WAIT SHALL increment the counter each cycle while the request stays high; on the edge that ends the LATENCY-th request cycle, the FSM leaves WAIT.
REQ-013 Write requests SHALL take priority over reads when both are high.
REQ-014 On a write exit from WAIT, the 64-bit value on dataM SHALL be written to line addressM[15:2] modulo MEM_LINES at that edge, and the FSM SHALL enter WDONE.
REQ-015 WDONE SHALL hold until writeM deasserts, committing no further writes. If readM is high when writeM drops, the FSM enters WAIT for a read with the counter reloaded to 1; otherwise it enters IDLE.
REQ-016 For a read, dataM SHALL be driven with the addressed line from the LATENCY-th request cycle onward, so the data is stable before the edge that ends that cycle. The FSM then enters RDATA.
REQ-017 RDATA SHALL keep driving the line, re-read every cycle from the current addressM, until readM deasserts; it then returns to IDLE with dataM high-Z the same cycle.
REQ-018 If the request drops during WAIT, the port SHALL abort to IDLE with no write and no drive.
REQ-019 If both ports write the same line on the same edge, the d-port value SHALL win.
REQ-020 A read SHALL return data committed on or before the edge that starts its first drive cycle; there is no same-cycle write bypass.
REQ-021 Address bits above log2(MEM_LINES)+1 SHALL be ignored, so addresses wrap onto the storage depth.

Reset
REQ-022 Asserting reset_n low SHALL immediately force both FSMs to IDLE, clear counters, and release both dataM buses to high-Z, including mid-request.
REQ-023 Storage contents SHALL NOT be cleared by reset.
REQ-024 After reset_n rises, a request already held high SHALL be treated as new and start at counter 1.

Configuration
REQ-025 With LINE_MEMORY_STATS_EN defined, the block SHALL add three 16-bit outputs:
- i_read_cnt: count of completed i-port reads.
- d_read_cnt: count of completed d-port reads.
- d_write_cnt: count of d-port write commits.
All three are zero on reset and saturate at 16'hFFFF.
REQ-026 Without LINE_MEMORY_STATS_EN, those ports and counters SHALL be absent and behaviour is otherwise identical.

Structure
REQ-027 A shared package mem_pkg SHALL hold WORD_SIZE=16, FETCH_SIZE=64, LINE_WORDS=4, and the port FSM state encoding.
REQ-028 One sub-module mem_port_fsm SHALL implement REQ-010..REQ-018, instantiated once per port; storage and arbitration stay in line_memory.

Verification
REQ-029 Preload line 0x012 with 64'h4444_3333_2222_1111. Hold d_readM high at d_addressM=16'h0048 from cycle 1 -> d_dataM equals that value in cycle 4 (LATENCY=4) and is high-Z in cycles 1-3.
REQ-030 Hold d_writeM high for 4 cycles with addr 16'h0010 and data 64'hDEAD_BEEF_0000_0001 in cycle 4. Then drop writeM and raise readM -> a single commit occurs, and the read returns 64'hDEAD_BEEF_0000_0001 four cycles later.
REQ-031 Run an i-port read of line 3 and a d-port read of line 7 concurrently -> both return correct lines in the same cycle with no interference.
REQ-032 Assert reset_n low in cycle 2 of a read -> dataM is high-Z immediately. A request held through reset release restarts and returns data 4 cycles after release.
REQ-033 Drop readM in cycle 2 -> no drive. Write to 16'hFFF0 with MEM_LINES=256 -> the data is readable at 16'h03F0.
REQ-034 With LINE_MEMORY_STATS_EN, run 3 d-reads and 2 d-writes -> d_read_cnt=3, d_write_cnt=2, i_read_cnt=0.
